simple_dual_sram_be: RTL and testbench
======================================

# simple_dual_sram_be

Parametrised simple dual-port SRAM for activation/weight buffering in the MMU datapath: one write port with per-byte enables, one read port with selectable read latency, write-first bypass on same-address collisions, and a hardware clear sequencer that zeroes the whole array on request. Sits between the DMA/feeder logic and the systolic array input staging, replacing plain single-byte-lane buffers where partial-word updates and fast buffer reuse are needed.

## Interface
- SRAM_DEPTH, 1024, number of words; power of two, ≥ 2
- DATA_WIDTH, 32, word width in bits; integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- OUT_REG, 1, 0: read latency 1 cycle; 1: extra output register, latency 2 cycles
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  pulse: start zeroing the whole array
- clr_busy  out  1  high while clear sweep in progress
- wea  in  1  write enable, port A
- wbea  in  NB  byte-lane write mask, port A
- addra  in  $clog2(SRAM_DEPTH)  write address
- dia  in  DATA_WIDTH  write data
- enb  in  1  read enable, port B
- addrb  in  $clog2(SRAM_DEPTH)  read address
- dob  out  DATA_WIDTH  read data
- dob_valid  out  1  dob carries data of a read issued LAT cycles earlier

## Operation
- LAT = 1 + OUT_REG.
- Write: wea && !clr_busy → for each lane i with wbea[i]=1, ram[addra][i] ← dia[i]; other lanes unchanged. wea with wbea=0 is a no-op.
- Read: enb && !clr_busy → ram[addrb] captured; presented on dob LAT cycles later with dob_valid=1 for exactly one cycle per accepted read.
- Collision (wea && enb && addra==addrb, same cycle): write-first; returned word = merged value (masked lanes from dia, others from old content).
- No read accepted → dob holds its last value, dob_valid=0.
- Clear FSM states IDLE, CLEAR:
  - IDLE: clr_req=1 → CLEAR next cycle, counter=0.
  - CLEAR: writes zero to ram[counter] each cycle, counter+1; after writing SRAM_DEPTH-1 → IDLE.
  - clr_busy = (state==CLEAR); high exactly SRAM_DEPTH cycles.
  - clr_req while CLEAR ignored (no restart).
  - wea/enb ignored while clr_busy; no dob_valid generated for them.
- clr_req and wea in same IDLE cycle: the write occurs, then is overwritten by the sweep.
- Reads accepted before clear start complete normally in the pipeline.

## Timing
- Reset values: dob=0, dob_valid=0, clr_busy=0, state=IDLE, counter=0. Array contents not reset.
- rst during CLEAR: sweep aborts next edge, partially cleared array, clr_busy=0.
- rst with reads in flight: in-flight reads dropped, no dob_valid after reset.
- Read latency: enb at cycle t → dob/dob_valid at t+LAT; back-to-back reads give one result per cycle.
- Write visible to a non-colliding read issued at t+1 or later.
- clr_req at t → clr_busy rises at t+1, falls at t+1+SRAM_DEPTH; first port access accepted at t+1+SRAM_DEPTH.

## Structure
- Package sram_pkg: clear-FSM state enum (IDLE, CLEAR), helper function for NB, elaboration check that DATA_WIDTH % BYTE_WIDTH == 0.
- Sub-module sram_clear_seq: clear FSM + address counter, outputs clr_busy, clr_addr, clr_we; the top muxes it onto port A.
- Storage: one array written per lane in a single clocked process, inferable as block RAM with byte-write.

## Test plan
- Byte mask: DEPTH=16, DATA_WIDTH=32; write 0xAABBCCDD to addr 3 (wbea=1111), then 0x11223344 with wbea=0101 → read addr 3 returns 0xAA22CC44.
- Collision: ram[5]=0x00000000; same cycle wea addr 5 data 0xDEADBEEF wbea=1100, enb addr 5 → dob=0xDEAD0000 at t+LAT.
- Latency: OUT_REG=0 and 1; reads of addrs 0..7 on consecutive cycles → dob_valid pulses start at t+1 / t+2, eight consecutive cycles, data in order.
- Clear: fill all 16 words with 0xFFFFFFFF, pulse clr_req → clr_busy high 16 cycles, writes/reads during it ignored, then all reads return 0.
- Reset mid-clear: rst at clear cycle 8 → clr_busy=0, dob_valid=0 next cycle; addrs 0..7 read 0, addrs 8..15 read 0xFFFFFFFF.
- Reset mid-read: rst one cycle after enb (OUT_REG=1) → no dob_valid pulse, dob=0.

Source files
------------

// File: rtl/simple_dual_sram_be_pkg.sv
// sram_pkg: shared types and elaboration helpers for simple_dual_sram_be.
//   clr_state_e : clear-sequencer state encoding (IDLE, CLEAR)
//   nb_of()     : number of byte-enable lanes for a word/lane width pair
//   lanes_ok()  : true when the word width splits evenly into lanes
package sram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int nb_of(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic bit lanes_ok(input int data_width, input int byte_width);
    return (byte_width > 0) && ((data_width % byte_width) == 0);
  endfunction

endpackage

// File: rtl/simple_dual_sram_be_if.sv
// simple_dual_sram_be_if: port bundle of the byte-enable simple dual-port SRAM.
//   clr_req/clr_busy             : clear-sweep request and busy flag
//   wea/wbea/addra/dia           : write port A with per-lane mask
//   enb/addrb                    : read port B request
//   dob/dob_valid                : read data and its one-cycle valid strobe
// master drives requests (feeder/DMA side), slave is the SRAM.
interface simple_dual_sram_be_if #(
  parameter int AW         = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NB         = 4
);
  logic                  clr_req;
  logic                  clr_busy;
  logic                  wea;
  logic [NB-1:0]         wbea;
  logic [AW-1:0]         addra;
  logic [DATA_WIDTH-1:0] dia;
  logic                  enb;
  logic [AW-1:0]         addrb;
  logic [DATA_WIDTH-1:0] dob;
  logic                  dob_valid;

  modport master (
    output clr_req, wea, wbea, addra, dia, enb, addrb,
    input  clr_busy, dob, dob_valid
  );

  modport slave (
    input  clr_req, wea, wbea, addra, dia, enb, addrb,
    output clr_busy, dob, dob_valid
  );
endinterface

// File: rtl/simple_dual_sram_be_clear_seq.sv
// sram_clear_seq: two-state sweep that walks every address once so the top
// can write zero into it.
//   clk, rst   : clock, synchronous active-high reset
//   clr_req    : start request, ignored while a sweep is running
//   clr_busy   : high for exactly SRAM_DEPTH cycles per sweep (registered)
//   clr_addr   : address to zero this cycle
//   clr_we     : zero-write strobe for clr_addr
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int SRAM_DEPTH = 1024,
  localparam int AW        = $clog2(SRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  clr_state_e    state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Clear FSM: busy and counter are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clr_req) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        CLEAR: begin
          // Last address written this cycle: leave the sweep.
          if (cnt_r == AW'(SRAM_DEPTH - 1)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + AW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_r;
  assign clr_addr = cnt_r;
  assign clr_we   = busy_r;

endmodule

// File: rtl/simple_dual_sram_be.sv
// simple_dual_sram_be: simple dual-port SRAM with per-byte write enables,
// write-first collision bypass, 1 or 2 cycle read latency and a hardware
// clear sweep.
//   clk, rst : clock, synchronous active-high reset (array not reset)
//   s        : simple_dual_sram_be_if.slave (write port A, read port B,
//              clear request/busy, read data/valid)
// While the sweep runs, port A is owned by the sequencer and both host
// ports are ignored.
module simple_dual_sram_be
  import sram_pkg::*;
#(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 1
) (
  input logic                   clk,
  input logic                   rst,
  simple_dual_sram_be_if.slave  s
);

  localparam int NB = nb_of(DATA_WIDTH, BYTE_WIDTH);
  localparam int AW = $clog2(SRAM_DEPTH);

  if (!lanes_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_lane_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  // Overlay the masked lanes of new_w onto old_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  logic                  clr_busy_s;
  logic [AW-1:0]         clr_addr_s;
  logic                  clr_we_s;
  logic [NB-1:0]         wr_en_s;
  logic [AW-1:0]         wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic                  rd_acc_s;
  logic                  coll_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_v1_r;
  logic [DATA_WIDTH-1:0] mem_r [SRAM_DEPTH];

  sram_clear_seq #(
    .SRAM_DEPTH (SRAM_DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (s.clr_req),
    .clr_busy (clr_busy_s),
    .clr_addr (clr_addr_s),
    .clr_we   (clr_we_s)
  );

  assign rd_acc_s = s.enb && !clr_busy_s;
  assign coll_s   = rd_acc_s && s.wea && (s.addra == s.addrb);

  // Port A owner select: reset blocks writes so an aborted sweep stops
  // exactly at the reset edge.
  always_comb begin
    wr_en_s   = '0;
    wr_addr_s = s.addra;
    wr_data_s = s.dia;
    if (rst) begin
      wr_en_s = '0;
    end else if (clr_we_s) begin
      wr_en_s   = '1;
      wr_addr_s = clr_addr_s;
      wr_data_s = '0;
    end else if (s.wea) begin
      wr_en_s = s.wbea;
    end else begin
      wr_en_s = '0;
    end
  end

  // Lane-wise array write, shaped for byte-write block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en_s[i]) begin
        mem_r[wr_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read word with write-first bypass on same-address collision.
  always_comb begin
    rd_word_s = mem_r[s.addrb];
    if (coll_s) begin
      rd_word_s = merge_lanes(mem_r[s.addrb], s.dia, s.wbea);
    end else begin
      rd_word_s = mem_r[s.addrb];
    end
  end

  // First read stage: data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
      rd_v1_r   <= 1'b0;
    end else begin
      rd_v1_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dob_r;
    logic                  dob_valid_r;

    // Optional second stage for timing closure on the read path.
    always_ff @(posedge clk) begin
      if (rst) begin
        dob_r       <= '0;
        dob_valid_r <= 1'b0;
      end else begin
        dob_valid_r <= rd_v1_r;
        if (rd_v1_r) begin
          dob_r <= rd_data_r;
        end
      end
    end

    assign s.dob       = dob_r;
    assign s.dob_valid = dob_valid_r;
  end else begin : g_no_out_reg
    assign s.dob       = rd_data_r;
    assign s.dob_valid = rd_v1_r;
  end

  assign s.clr_busy = clr_busy_s;

endmodule

// File: tb/tb_simple_dual_sram_be.sv
// Directed bench for simple_dual_sram_be: two instances (OUT_REG=0 and 1)
// receive identical stimulus; each read result is checked at its own latency.
module tb_simple_dual_sram_be;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  simple_dual_sram_be_if #(.AW(AW), .DATA_WIDTH(DW), .NB(NB)) if0 ();
  simple_dual_sram_be_if #(.AW(AW), .DATA_WIDTH(DW), .NB(NB)) if1 ();

  assign if1.clr_req = if0.clr_req;
  assign if1.wea     = if0.wea;
  assign if1.wbea    = if0.wbea;
  assign if1.addra   = if0.addra;
  assign if1.dia     = if0.dia;
  assign if1.enb     = if0.enb;
  assign if1.addrb   = if0.addrb;

  simple_dual_sram_be #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .OUT_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .s   (if0)
  );

  simple_dual_sram_be #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .OUT_REG(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .s   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    if0.wea   = 1'b1;
    if0.addra = a;
    if0.dia   = d;
    if0.wbea  = m;
    cyc();
    if0.wea   = 1'b0;
    if0.wbea  = 4'b0000;
  endtask

  // Issue one read; return what each instance shows at its own latency.
  task automatic do_read(input logic [AW-1:0] a, output logic v0, output logic [DW-1:0] d0,
                         output logic v1, output logic [DW-1:0] d1);
    if0.enb   = 1'b1;
    if0.addrb = a;
    cyc();
    if0.enb = 1'b0;
    v0 = if0.dob_valid;
    d0 = if0.dob;
    cyc();
    v1 = if1.dob_valid;
    d1 = if1.dob;
  endtask

  task automatic fill_all(input logic [DW-1:0] d);
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), d, 4'b1111);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({if0.dob_valid, if1.dob_valid, if0.clr_busy, if1.clr_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {if0.dob_valid, if1.dob_valid, if0.clr_busy, if1.clr_busy});
    end
    checks++;
    if ({if0.dob, if1.dob} !== 64'h0) begin
      failures++;
      $display("FAIL reset_dob: got %h/%h expected 0/0", if0.dob, if1.dob);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_byte_mask();
    logic v0, v1;
    logic [DW-1:0] d0, d1;
    do_write(4'd3, 32'hAABB_CCDD, 4'b1111);
    do_write(4'd3, 32'h1122_3344, 4'b0101);
    do_read(4'd3, v0, d0, v1, d1);
    checks++;
    if ({v0, v1, d0, d1} !== {1'b1, 1'b1, 32'hAA22_CC44, 32'hAA22_CC44}) begin
      failures++;
      $display("FAIL byte_mask: got v%b%b %h/%h expected v11 aa22cc44", v0, v1, d0, d1);
    end
    do_write(4'd3, 32'h0000_0000, 4'b0000);
    do_read(4'd3, v0, d0, v1, d1);
    checks++;
    if ({v0, v1, d0, d1} !== {1'b1, 1'b1, 32'hAA22_CC44, 32'hAA22_CC44}) begin
      failures++;
      $display("FAIL empty_mask_noop: got v%b%b %h/%h expected v11 aa22cc44", v0, v1, d0, d1);
    end
  endtask

  task automatic test_collision();
    logic v0, v1;
    logic [DW-1:0] d0, d1;
    do_write(4'd5, 32'h0000_0000, 4'b1111);
    if0.wea   = 1'b1;
    if0.addra = 4'd5;
    if0.dia   = 32'hDEAD_BEEF;
    if0.wbea  = 4'b1100;
    if0.enb   = 1'b1;
    if0.addrb = 4'd5;
    cyc();
    if0.wea  = 1'b0;
    if0.wbea = 4'b0000;
    if0.enb  = 1'b0;
    checks++;
    if ({if0.dob_valid, if0.dob} !== {1'b1, 32'hDEAD_0000}) begin
      failures++;
      $display("FAIL collision_lat1: got v%b %h expected v1 dead0000", if0.dob_valid, if0.dob);
    end
    cyc();
    checks++;
    if ({if1.dob_valid, if1.dob} !== {1'b1, 32'hDEAD_0000}) begin
      failures++;
      $display("FAIL collision_lat2: got v%b %h expected v1 dead0000", if1.dob_valid, if1.dob);
    end
    do_read(4'd5, v0, d0, v1, d1);
    checks++;
    if ({d0, d1} !== {32'hDEAD_0000, 32'hDEAD_0000}) begin
      failures++;
      $display("FAIL collision_stored: got %h/%h expected dead0000", d0, d1);
    end
  endtask

  task automatic test_latency();
    logic e0v, e1v;
    for (int i = 0; i < 8; i++) begin
      do_write(AW'(i), 32'hC0DE_0000 | 32'(i), 4'b1111);
    end
    for (int k = 0; k < 10; k++) begin
      if0.enb   = (k < 8);
      if0.addrb = AW'(k);
      cyc();
      e0v = (k < 8);
      e1v = (k >= 1) && (k <= 8);
      checks++;
      if (if0.dob_valid !== e0v || (e0v && if0.dob !== (32'hC0DE_0000 | 32'(k)))) begin
        failures++;
        $display("FAIL latency0 k=%0d: got v%b %h expected v%b c0de%04h", k, if0.dob_valid, if0.dob, e0v, k);
      end
      checks++;
      if (if1.dob_valid !== e1v || (e1v && if1.dob !== (32'hC0DE_0000 | 32'(k - 1)))) begin
        failures++;
        $display("FAIL latency1 k=%0d: got v%b %h expected v%b c0de%04h", k, if1.dob_valid, if1.dob, e1v, k - 1);
      end
    end
    if0.enb = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cycles;
    logic v0, v1;
    logic [DW-1:0] d0, d1;
    fill_all(32'hFFFF_FFFF);
    if0.clr_req = 1'b1;
    cyc();
    if0.clr_req = 1'b0;
    busy_cycles = 0;
    while (if0.clr_busy === 1'b1 && busy_cycles < 40) begin
      if0.wea   = 1'b1;
      if0.addra = 4'd2;
      if0.dia   = 32'h1234_5678;
      if0.wbea  = 4'b1111;
      if0.enb   = 1'b1;
      if0.addrb = 4'd2;
      // A second request mid-sweep must not restart it.
      if0.clr_req = (busy_cycles == 4);
      cyc();
      checks++;
      if ({if0.dob_valid, if1.dob_valid} !== 2'b00) begin
        failures++;
        $display("FAIL clear_read_ignored c=%0d: got %b expected 00", busy_cycles, {if0.dob_valid, if1.dob_valid});
      end
      busy_cycles++;
    end
    if0.wea     = 1'b0;
    if0.wbea    = 4'b0000;
    if0.enb     = 1'b0;
    if0.clr_req = 1'b0;
    checks++;
    if (busy_cycles != DEPTH) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d expected %0d", busy_cycles, DEPTH);
    end
    cyc();
    checks++;
    if (if1.dob_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_tail_valid: got %b expected 0", if1.dob_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), v0, d0, v1, d1);
      checks++;
      if ({v0, v1, d0, d1} !== {1'b1, 1'b1, 64'h0}) begin
        failures++;
        $display("FAIL clear_zero a=%0d: got v%b%b %h/%h expected v11 0", i, v0, v1, d0, d1);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic v0, v1;
    logic [DW-1:0] d0, d1;
    logic [DW-1:0] exp;
    fill_all(32'hFFFF_FFFF);
    if0.clr_req = 1'b1;
    cyc();
    if0.clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({if0.clr_busy, if1.clr_busy, if0.dob_valid, if1.dob_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL midclear_abort: got %b expected 0000",
               {if0.clr_busy, if1.clr_busy, if0.dob_valid, if1.dob_valid});
    end
    rst = 1'b0;
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < 8) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      do_read(AW'(i), v0, d0, v1, d1);
      checks++;
      if ({d0, d1} !== {exp, exp}) begin
        failures++;
        $display("FAIL midclear_content a=%0d: got %h/%h expected %h", i, d0, d1, exp);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    if0.enb   = 1'b1;
    if0.addrb = 4'd9;
    cyc();
    if0.enb = 1'b0;
    rst     = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({if1.dob_valid, if1.dob} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL midread_reset: got v%b %h expected v0 0", if1.dob_valid, if1.dob);
    end
    cyc();
    checks++;
    if ({if1.dob_valid, if1.dob, if0.dob_valid} !== {1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL midread_dropped: got v%b %h v0=%b expected v0 0 v0=0", if1.dob_valid, if1.dob, if0.dob_valid);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    if0.clr_req = 1'b0;
    if0.wea     = 1'b0;
    if0.wbea    = 4'b0000;
    if0.addra   = 4'd0;
    if0.dia     = 32'h0;
    if0.enb     = 1'b0;
    if0.addrb   = 4'd0;
    cyc();
    test_reset();
    test_byte_mask();
    test_collision();
    test_latency();
    test_clear();
    test_reset_mid_clear();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
